// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: 5-stage pipeline hazard unit with M/W forwarding, multi-bubble load-use
// stalls and a register scoreboard for one outstanding out-of-order MDU op.
module hazard_unit_sb #(
    parameter int NREG        = 32,
    parameter int AW          = 5,
    parameter int LOAD_LAT    = 1,
    parameter int BYPASS_DONE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1D,
    input  logic [AW-1:0]   raddr2D,
    input  logic            rs1_useD,
    input  logic            rs2_useD,
    input  logic [AW-1:0]   waddrD,
    input  logic            reg_wrD,
    input  logic            mdu_opD,
    input  logic [AW-1:0]   raddr1E,
    input  logic [AW-1:0]   raddr2E,
    input  logic [AW-1:0]   waddrE,
    input  logic            memrdE,
    input  logic            mdu_startE,
    input  logic            reg_wrM,
    input  logic            reg_wrW,
    input  logic [AW-1:0]   waddrM,
    input  logic [AW-1:0]   waddrW,
    input  logic            mdu_done,
    input  logic [AW-1:0]   mdu_waddr,
    input  logic            br_taken,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [1:0]      For_A,
    output logic [1:0]      For_B,
    output logic            mdu_busy,
    output logic [NREG-1:0] sb_pending
);
    logic [2:0]      r_lcnt;
    logic            r_busy;
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_pend;
    logic            w_lu_det;
    logic            w_lu_stall;
    logic            w_raw;
    logic            w_waw;
    logic            w_struct;
    logic            w_stall;

    // x0 is never tracked, so a set aimed at it is dropped and bit 0 stays clear.
    assign w_set = (mdu_startE && waddrE != '0) ? NREG'(1) << waddrE : '0;
    assign w_clr = mdu_done ? NREG'(1) << mdu_waddr : '0;
    assign w_pend = (BYPASS_DONE != 0) ? (r_pend & ~w_clr) : r_pend;

    assign w_lu_det = memrdE &&
        ((rs1_useD && raddr1D != '0 && raddr1D == waddrE) ||
         (rs2_useD && raddr2D != '0 && raddr2D == waddrE));
    assign w_lu_stall = w_lu_det || r_lcnt != 3'd0;

    assign w_raw = (rs1_useD && raddr1D != '0 && w_pend[raddr1D]) ||
                   (rs2_useD && raddr2D != '0 && w_pend[raddr2D]);
    assign w_waw = reg_wrD && waddrD != '0 && w_pend[waddrD];
    assign w_struct = mdu_opD && (r_busy || mdu_startE);
    assign w_stall = w_lu_stall || w_raw || w_waw || w_struct;

    // A taken branch squashes the D instruction, so there is nothing worth holding.
    assign StallF = w_stall && !br_taken;
    assign StallD = w_stall && !br_taken;
    assign FlushD = br_taken;
    assign FlushE = br_taken || w_stall;

    assign For_A = (raddr1E != '0 && raddr1E == waddrM && reg_wrM) ? 2'b10 :
                   (raddr1E != '0 && raddr1E == waddrW && reg_wrW) ? 2'b01 : 2'b00;
    assign For_B = (raddr2E != '0 && raddr2E == waddrM && reg_wrM) ? 2'b10 :
                   (raddr2E != '0 && raddr2E == waddrW && reg_wrW) ? 2'b01 : 2'b00;

    assign mdu_busy   = r_busy;
    assign sb_pending = r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt <= 3'd0;
            r_busy <= 1'b0;
            r_pend <= '0;
        end else begin
            r_lcnt <= br_taken ? 3'd0 :
                      (r_lcnt != 3'd0) ? r_lcnt - 3'd1 :
                      w_lu_det ? 3'(LOAD_LAT - 1) : 3'd0;
            r_busy <= mdu_startE ? 1'b1 : mdu_done ? 1'b0 : r_busy;
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: directed scoreboard bench; two instances (no-bypass / bypass, LOAD_LAT=3)
// share all inputs, expectations are queued by the stimulus and popped by a negedge monitor.
module tb_hazard_unit_sb;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] raddr1D, raddr2D, waddrD, raddr1E, raddr2E, waddrE, waddrM, waddrW, mdu_waddr;
    logic rs1_useD, rs2_useD, reg_wrD, mdu_opD, memrdE, mdu_startE;
    logic reg_wrM, reg_wrW, mdu_done, br_taken;
    logic sf0, sd0, fd0, fe0, busy0, sf1, sd1, fd1, fe1, busy1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [31:0] pend0, pend1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string nm;
        logic s0, s1, fd;
        logic [1:0] fa, fb;
        logic busy;
        logic [31:0] pend;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    hazard_unit_sb #(.NREG(32), .AW(5), .LOAD_LAT(3), .BYPASS_DONE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .raddr1D(raddr1D), .raddr2D(raddr2D),
        .rs1_useD(rs1_useD), .rs2_useD(rs2_useD), .waddrD(waddrD), .reg_wrD(reg_wrD),
        .mdu_opD(mdu_opD), .raddr1E(raddr1E), .raddr2E(raddr2E), .waddrE(waddrE),
        .memrdE(memrdE), .mdu_startE(mdu_startE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW),
        .waddrM(waddrM), .waddrW(waddrW), .mdu_done(mdu_done), .mdu_waddr(mdu_waddr),
        .br_taken(br_taken), .StallF(sf0), .StallD(sd0), .FlushD(fd0), .FlushE(fe0),
        .For_A(fa0), .For_B(fb0), .mdu_busy(busy0), .sb_pending(pend0));

    hazard_unit_sb #(.NREG(32), .AW(5), .LOAD_LAT(3), .BYPASS_DONE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .raddr1D(raddr1D), .raddr2D(raddr2D),
        .rs1_useD(rs1_useD), .rs2_useD(rs2_useD), .waddrD(waddrD), .reg_wrD(reg_wrD),
        .mdu_opD(mdu_opD), .raddr1E(raddr1E), .raddr2E(raddr2E), .waddrE(waddrE),
        .memrdE(memrdE), .mdu_startE(mdu_startE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW),
        .waddrM(waddrM), .waddrW(waddrW), .mdu_done(mdu_done), .mdu_waddr(mdu_waddr),
        .br_taken(br_taken), .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1),
        .For_A(fa1), .For_B(fb1), .mdu_busy(busy1), .sb_pending(pend1));

    task automatic chk(input string nm, input int inst, input logic [39:0] act, input logic [39:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s u%0d: {sf,sd,fd,fe,fa,fb,busy,pend} got=%h want=%h", nm, inst, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mdu_startE && busy0) begin
            fails++;
            $display("FAIL proto: mdu_startE while busy got=1 want=0");
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, 0, {sf0, sd0, fd0, fe0, fa0, fb0, busy0, pend0},
                {e.s0, e.s0, e.fd, e.fd | e.s0, e.fa, e.fb, e.busy, e.pend});
            chk(e.nm, 1, {sf1, sd1, fd1, fe1, fa1, fb1, busy1, pend1},
                {e.s1, e.s1, e.fd, e.fd | e.s1, e.fa, e.fb, e.busy, e.pend});
        end
    end

    task automatic push(input string nm, input logic s0, input logic s1, input logic fd,
                        input logic [1:0] fa, input logic [1:0] fb, input logic busy,
                        input logic [31:0] pend);
        exp_t x;
        x.nm = nm; x.s0 = s0; x.s1 = s1; x.fd = fd; x.fa = fa; x.fb = fb; x.busy = busy; x.pend = pend;
        q.push_back(x);
    endtask

    task automatic step(input string nm, input logic s0, input logic s1, input logic fd,
                        input logic [1:0] fa, input logic [1:0] fb, input logic busy,
                        input logic [31:0] pend);
        push(nm, s0, s1, fd, fa, fb, busy, pend);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {raddr1D, raddr2D, waddrD, raddr1E, raddr2E, waddrE, waddrM, waddrW, mdu_waddr} = '0;
        {rs1_useD, rs2_useD, reg_wrD, mdu_opD, memrdE, mdu_startE} = '0;
        {reg_wrM, reg_wrW, mdu_done, br_taken} = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("rst", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        br_taken = 1;
        step("rst_br", 0, 0, 1, 2'b00, 2'b00, 0, 32'h0);
        rst_n = 1'b1;
        br_taken = 0;
        // forwarding priority and x0 exclusion
        raddr1E = 5; raddr2E = 5; waddrM = 5; reg_wrM = 1; waddrW = 5; reg_wrW = 1;
        step("fwd_m", 0, 0, 0, 2'b10, 2'b10, 0, 32'h0);
        reg_wrM = 0;
        step("fwd_w", 0, 0, 0, 2'b01, 2'b01, 0, 32'h0);
        raddr1E = 0;
        step("fwd_x0", 0, 0, 0, 2'b00, 2'b01, 0, 32'h0);
        raddr2E = 3; waddrM = 3; reg_wrM = 1; waddrW = 3;
        step("fwd_b_m", 0, 0, 0, 2'b00, 2'b10, 0, 32'h0);
        idle();
        // load-use: three bubbles then release
        memrdE = 1; waddrE = 7; raddr2D = 7; rs2_useD = 1;
        step("lu_0", 1, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        memrdE = 0; waddrE = 0;
        step("lu_1", 1, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        step("lu_2", 1, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        step("lu_3", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        memrdE = 1; waddrE = 7; rs2_useD = 0;
        step("lu_nouse", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        memrdE = 1; rs1_useD = 1;
        step("lu_x0", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        // scoreboard RAW on x9
        mdu_startE = 1; waddrE = 9;
        step("raw_issue", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        raddr1D = 9; rs1_useD = 1;
        step("raw_1", 1, 1, 0, 2'b00, 2'b00, 1, 32'h200);
        step("raw_2", 1, 1, 0, 2'b00, 2'b00, 1, 32'h200);
        mdu_done = 1; mdu_waddr = 9;
        step("raw_done", 1, 0, 0, 2'b00, 2'b00, 1, 32'h200);
        mdu_done = 0; mdu_waddr = 0;
        step("raw_rel", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        // WAW and structural on x12
        mdu_startE = 1; waddrE = 12;
        step("waw_issue", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        reg_wrD = 1; waddrD = 12;
        step("waw", 1, 1, 0, 2'b00, 2'b00, 1, 32'h1000);
        idle();
        mdu_opD = 1;
        step("struct_busy", 1, 1, 0, 2'b00, 2'b00, 1, 32'h1000);
        mdu_done = 1; mdu_waddr = 12;
        step("struct_done", 1, 1, 0, 2'b00, 2'b00, 1, 32'h1000);
        mdu_done = 0; mdu_waddr = 0;
        step("struct_rel", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        mdu_startE = 1;
        step("struct_start", 1, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        step("x0_busy", 0, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        mdu_done = 1;
        step("x0_done", 0, 0, 0, 2'b00, 2'b00, 1, 32'h0);
        idle();
        // simultaneous set/clear on x5: set wins
        mdu_startE = 1; waddrE = 5; mdu_done = 1; mdu_waddr = 5;
        step("sc_same", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        step("sc_kept", 0, 0, 0, 2'b00, 2'b00, 1, 32'h20);
        mdu_done = 1; mdu_waddr = 5;
        step("sc_done", 0, 0, 0, 2'b00, 2'b00, 1, 32'h20);
        idle();
        step("sc_clear", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        // branch overrides load-use with lcnt=2
        memrdE = 1; waddrE = 7; raddr2D = 7; rs2_useD = 1;
        step("br_lu", 1, 1, 0, 2'b00, 2'b00, 0, 32'h0);
        br_taken = 1;
        step("br_win", 0, 0, 1, 2'b00, 2'b00, 0, 32'h0);
        br_taken = 0; memrdE = 0; waddrE = 0;
        step("br_lcnt0", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        // asynchronous reset mid-operation
        mdu_startE = 1; waddrE = 4;
        step("rm_issue", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        memrdE = 1; waddrE = 7; raddr2D = 7; rs2_useD = 1;
        step("rm_lu", 1, 1, 0, 2'b00, 2'b00, 1, 32'h10);
        idle();
        raddr1D = 4; rs1_useD = 1;
        push("rm_async", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rm_after", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        step("rm_after2", 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        idle();
        @(posedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: queue depth got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
